// File: rtl/register_file.sv
// rtl/register_file.sv - 8x16 register file, two async read ports, one sync write port
// r0 reads as zero; define REG_FILE_BYPASS_EN for same-cycle write-through forwarding.
module register_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RW_en,
   input  logic [ADDR_W-1:0] RW_dest,
   input  logic [ADDR_W-1:0] RR_addr_1,
   input  logic [ADDR_W-1:0] RR_addr_2,
   input  logic [DATA_W-1:0] RW_data,
   output logic [DATA_W-1:0] RR_data_1,
   output logic [DATA_W-1:0] RR_data_2
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wr_ok;

   // Address 0 is never written, so regs_q[0] keeps its reset value of zero.
   assign wr_ok = RW_en && (RW_dest != '0);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_ok) begin
         regs_d[RW_dest] = RW_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= DATA_W'(i);
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      RR_data_1 = (RR_addr_1 == '0) ? '0 : regs_q[RR_addr_1];
      RR_data_2 = (RR_addr_2 == '0) ? '0 : regs_q[RR_addr_2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (RR_addr_1 == RW_dest)) begin
         RR_data_1 = RW_data;
      end
      if (wr_ok && (RR_addr_2 == RW_dest)) begin
         RR_data_2 = RW_data;
      end
`endif
   end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
// Expected read data is queued by the stimulus and checked by a separate monitor.
module tb_register_file;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              rst_n;
   logic              RW_en;
   logic [ADDR_W-1:0] RW_dest;
   logic [ADDR_W-1:0] RR_addr_1;
   logic [ADDR_W-1:0] RR_addr_2;
   logic [DATA_W-1:0] RW_data;
   logic [DATA_W-1:0] RR_data_1;
   logic [DATA_W-1:0] RR_data_2;

   typedef struct {
      string             name;
      logic [DATA_W-1:0] exp1;
      logic [DATA_W-1:0] exp2;
   } sb_entry_t;

   sb_entry_t sb[$];
   event      sample_ev;
   int        checks = 0;
   int        errors = 0;

   register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RW_en     (RW_en),
      .RW_dest   (RW_dest),
      .RR_addr_1 (RR_addr_1),
      .RR_addr_2 (RR_addr_2),
      .RW_data   (RW_data),
      .RR_data_1 (RR_data_1),
      .RR_data_2 (RR_data_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      sb_entry_t e;
      forever begin
         @(sample_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (RR_data_1 !== e.exp1) begin
               errors++;
               $display("FAIL %s port1: got %h expected %h", e.name, RR_data_1, e.exp1);
            end
            checks++;
            if (RR_data_2 !== e.exp2) begin
               errors++;
               $display("FAIL %s port2: got %h expected %h", e.name, RR_data_2, e.exp2);
            end
         end
      end
   end

   task automatic expect_read(input string name, input logic [ADDR_W-1:0] a1,
                              input logic [ADDR_W-1:0] a2,
                              input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
      RR_addr_1 = a1;
      RR_addr_2 = a2;
      #1;
      sb.push_back('{name, e1, e2});
      ->sample_ev;
      #1;
   endtask

   task automatic do_write(input logic en, input logic [ADDR_W-1:0] dest,
                           input logic [DATA_W-1:0] data);
      @(negedge clk);
      RW_en   = en;
      RW_dest = dest;
      RW_data = data;
      @(posedge clk);
      @(negedge clk);
      RW_en   = 1'b0;
   endtask

   initial begin
      int wait_cnt;
      rst_n     = 1'b1;
      RW_en     = 1'b0;
      RW_dest   = '0;
      RW_data   = '0;
      RR_addr_1 = '0;
      RR_addr_2 = '0;
      #2;
      rst_n = 1'b0;
      expect_read("reset_6_4_in_reset", 3'd6, 3'd4, 16'd6, 16'd4);
      expect_read("reset_0_7_in_reset", 3'd0, 3'd7, 16'd0, 16'd7);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expect_read("reset_6_4", 3'd6, 3'd4, 16'd6, 16'd4);
      expect_read("reset_1_5", 3'd1, 3'd5, 16'd1, 16'd5);

      do_write(1'b1, 3'd4, 16'd8);
      expect_read("write_r4", 3'd6, 3'd4, 16'd6, 16'd8);

      do_write(1'b0, 3'd5, 16'hBEEF);
      expect_read("no_write_r5", 3'd5, 3'd5, 16'd5, 16'd5);

      do_write(1'b1, 3'd0, 16'hFFFF);
      expect_read("r0_ignored", 3'd0, 3'd0, 16'd0, 16'd0);

      do_write(1'b1, 3'd7, 16'hFFFF);
      expect_read("write_r7", 3'd7, 3'd4, 16'hFFFF, 16'd8);

      // Write to r0 in the same cycle as a read of r0: no forwarding either way.
      @(negedge clk);
      RW_en   = 1'b1;
      RW_dest = 3'd0;
      RW_data = 16'h5555;
      expect_read("r0_same_cycle", 3'd0, 3'd0, 16'd0, 16'd0);
      @(posedge clk);
      @(negedge clk);
      RW_en = 1'b0;

      do_write(1'b1, 3'd3, 16'h1234);
      expect_read("write_r3", 3'd3, 3'd2, 16'h1234, 16'd2);
      rst_n = 1'b0;
      expect_read("async_reset_r3", 3'd3, 3'd4, 16'd3, 16'd4);
      expect_read("async_reset_r7", 3'd7, 3'd0, 16'd7, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      RW_en   = 1'b1;
      RW_dest = 3'd2;
      RW_data = 16'hA5A5;
`ifdef REG_FILE_BYPASS_EN
      expect_read("pre_edge_r2", 3'd2, 3'd1, 16'hA5A5, 16'd1);
      expect_read("pre_edge_r2_p2", 3'd6, 3'd2, 16'd6, 16'hA5A5);
`else
      expect_read("pre_edge_r2", 3'd2, 3'd1, 16'd2, 16'd1);
      expect_read("pre_edge_r2_p2", 3'd6, 3'd2, 16'd6, 16'd2);
`endif
      @(posedge clk);
      @(negedge clk);
      RW_en = 1'b0;
      expect_read("post_edge_r2", 3'd2, 3'd2, 16'hA5A5, 16'hA5A5);

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 100) begin
         ->sample_ev;
         #1;
         wait_cnt++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
